approx_err_monitor: RTL and testbench

Synthesizable, parametrised on-chip error-characterisation block for the ETA-I approximate adder. It streams operand pairs through an approximate adder and an exact adder in parallel. Over a programmable window it accumulates the sample count, sum of absolute error (SAE), sum of squared error (SSE), maximum absolute error and the count of erroneous samples. These metrics were previously derived offline from testbench dumps; this block produces them in hardware, in the same adder-characterisation flow, for silicon and FPGA runs.

---
 rtl/approx_err_pkg.sv | 38 +++
 rtl/approx_err_monitor_eta1_adder.sv | 47 ++++
 rtl/approx_err_monitor.sv | 192 +++++++++++++++++++
 tb/tb_approx_err_monitor.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/approx_err_pkg.sv
`default_nettype none
// ============================================================================
// Module      : approx_err_pkg
// Description : Shared types and helpers for the ETA-I error monitor.
//               - state_t    : window FSM states
//               - PIPE_DEPTH : S1 sums, S2 errors, S3 accumulators
//               - sat_add    : saturating add on operands up to 128 bits
// Revision    : 1.0 - initial release
// ============================================================================
package approx_err_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int PIPE_DEPTH = 3;

    // Adds two values and clamps the result to the all-ones value of a
    // w-bit field. Callers zero-extend into 128 bits and truncate back, so
    // accumulators up to 128 bits wide are supported.
    function automatic logic [127:0] sat_add(input logic [127:0] a,
                                             input logic [127:0] b,
                                             input int           w);
        logic [128:0] sum;
        logic [127:0] lim;
        lim = (w >= 128) ? '1 : ((128'd1 << w) - 128'd1);
        sum = {1'b0, a} + {1'b0, b};
        if (sum > {1'b0, lim}) begin
            return lim;
        end
        return sum[127:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/approx_err_monitor_eta1_adder.sv
`default_nettype none
// ============================================================================
// Module      : eta1_adder
// Description : Combinational ETA-I approximate adder.
//               Upper segment [WIDTH-1:APPROX_BITS] is an exact add with no
//               carry-in; its carry-out is sum bit WIDTH. The lower segment
//               emits a^b scanning from the MSB down, and from the first bit
//               where both operands are 1 that bit and all lower bits are 1.
// Ports       : i_a, i_b [WIDTH-1:0] unsigned operands
//               o_sum    [WIDTH:0]   approximate sum
// Revision    : 1.0 - initial release
// ============================================================================
module eta1_adder #(
    parameter int WIDTH       = 32,
    parameter int APPROX_BITS = 16
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH:0]   o_sum
);

    localparam int c_UP_W = WIDTH - APPROX_BITS;

    logic [c_UP_W:0]        w_upper;
    logic [APPROX_BITS-1:0] w_lower;
    logic                   w_force;

    assign w_upper = {1'b0, i_a[WIDTH-1:APPROX_BITS]} + {1'b0, i_b[WIDTH-1:APPROX_BITS]};

    // Once a generate condition (both bits set) is seen, the carry that the
    // exact adder would propagate upward is approximated by saturating the
    // remaining lower bits to 1.
    always_comb begin
        w_force = 1'b0;
        w_lower = '0;
        for (int i = APPROX_BITS - 1; i >= 0; i--) begin
            if (i_a[i] && i_b[i]) begin
                w_force = 1'b1;
            end
            w_lower[i] = w_force ? 1'b1 : (i_a[i] ^ i_b[i]);
        end
    end

    assign o_sum = {w_upper, w_lower};

endmodule
`default_nettype wire

// File: rtl/approx_err_monitor.sv
`default_nettype none
// ============================================================================
// Module      : approx_err_monitor
// Description : Streams operand pairs through the ETA-I approximate adder and
//               an exact adder and accumulates error metrics over a window.
// Ports       : clk, rst_n            clock, async active-low reset
//               start, win_len        open a window of win_len samples
//               in_valid/in_ready     operand handshake, in_a/in_b operands
//               busy                  window in progress
//               res_valid/res_ack     result handshake
//               res_count, res_err_cnt, res_max_ae, res_sae, res_sse results
// Revision    : 1.0 - initial release
// ============================================================================
module approx_err_monitor
    import approx_err_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int APPROX_BITS = 16,
    parameter int CNT_W       = 16,
    parameter int ACC_W       = 80   // 2*(WIDTH+1) <= ACC_W <= 128
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] win_len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             busy,
    output logic             res_valid,
    input  logic             res_ack,
    output logic [CNT_W-1:0] res_count,
    output logic [CNT_W-1:0] res_err_cnt,
    output logic [WIDTH:0]   res_max_ae,
    output logic [ACC_W-1:0] res_sae,
    output logic [ACC_W-1:0] res_sse
);

    localparam int               c_SE_W = 2 * (WIDTH + 1);
    localparam logic [CNT_W-1:0] c_ONE  = CNT_W'(1);

    state_t r_state, w_state_nxt;
    logic   w_clear;
    logic   w_accept;

    logic [CNT_W-1:0] r_len;
    logic [CNT_W-1:0] r_acc_cnt;

    // r_vld[0] qualifies S1, r_vld[1] qualifies S2; S3 is the accumulators.
    logic [PIPE_DEPTH-2:0] r_vld;
    logic [WIDTH:0]        r_exact, r_approx;
    logic [WIDTH:0]        r_ae;
    logic [c_SE_W-1:0]     r_se;
    logic                  r_nz;

    logic [WIDTH:0]    w_approx;
    logic [WIDTH:0]    w_ae;
    logic [c_SE_W-1:0] w_ae_ext;

    logic [CNT_W-1:0] r_count, r_err_cnt;
    logic [WIDTH:0]   r_max_ae;
    logic [ACC_W-1:0] r_sae, r_sse;

    eta1_adder #(
        .WIDTH       (WIDTH),
        .APPROX_BITS (APPROX_BITS)
    ) u_eta1 (
        .i_a   (in_a),
        .i_b   (in_b),
        .o_sum (w_approx)
    );

    assign w_accept = in_valid && in_ready;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_clear     = 1'b0;
        in_ready    = 1'b0;
        busy        = 1'b1;
        res_valid   = 1'b0;
        case (r_state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_clear     = 1'b1;
                    w_state_nxt = (win_len == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                in_ready = 1'b1;
                // Leaving RUN on the last accept drops in_ready right after it.
                if (in_valid && (r_acc_cnt == r_len - c_ONE)) begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (r_vld == '0) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                res_valid = 1'b1;
                if (res_ack) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // ---------------- window counters ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_len     <= '0;
            r_acc_cnt <= '0;
        end else if (w_clear) begin
            r_len     <= win_len;
            r_acc_cnt <= '0;
        end else if (w_accept) begin
            r_acc_cnt <= r_acc_cnt + c_ONE;
        end
    end

    // ---------------- pipeline S1 / S2 ----------------
    assign w_ae     = (r_exact >= r_approx) ? (r_exact - r_approx) : (r_approx - r_exact);
    assign w_ae_ext = c_SE_W'(w_ae);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld    <= '0;
            r_exact  <= '0;
            r_approx <= '0;
            r_ae     <= '0;
            r_se     <= '0;
            r_nz     <= 1'b0;
        end else begin
            r_vld <= {r_vld[PIPE_DEPTH-3:0], w_accept};
            if (w_accept) begin
                r_exact  <= {1'b0, in_a} + {1'b0, in_b};
                r_approx <= w_approx;
            end
            if (r_vld[0]) begin
                r_ae <= w_ae;
                r_se <= w_ae_ext * w_ae_ext;
                r_nz <= (w_ae != '0);
            end
        end
    end

    // ---------------- S3 accumulators (double as results) ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count   <= '0;
            r_err_cnt <= '0;
            r_max_ae  <= '0;
            r_sae     <= '0;
            r_sse     <= '0;
        end else if (w_clear) begin
            r_count   <= '0;
            r_err_cnt <= '0;
            r_max_ae  <= '0;
            r_sae     <= '0;
            r_sse     <= '0;
        end else if (r_vld[PIPE_DEPTH-2]) begin
            r_count   <= r_count + c_ONE;
            r_err_cnt <= r_err_cnt + CNT_W'(r_nz);
            if (r_ae > r_max_ae) begin
                r_max_ae <= r_ae;
            end
            r_sae <= ACC_W'(sat_add(128'(r_sae), 128'(r_ae), ACC_W));
            r_sse <= ACC_W'(sat_add(128'(r_sse), 128'(r_se), ACC_W));
        end
    end

    assign res_count   = r_count;
    assign res_err_cnt = r_err_cnt;
    assign res_max_ae  = r_max_ae;
    assign res_sae     = r_sae;
    assign res_sse     = r_sse;

endmodule
`default_nettype wire

// File: tb/tb_approx_err_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_approx_err_monitor
// Description : Self-checking bench for approx_err_monitor (WIDTH=8,
//               APPROX_BITS=4). Two instances share stimulus: one with wide
//               accumulators and one with ACC_W=18 to exercise saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_approx_err_monitor;

    localparam int W   = 8;
    localparam int AB  = 4;
    localparam int CW  = 16;
    localparam int AW  = 80;
    localparam int AWS = 18;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          start;
    logic [CW-1:0] win_len;
    logic          in_valid;
    logic [W-1:0]  in_a, in_b;
    logic          res_ack;

    logic          in_ready, busy, res_valid;
    logic [CW-1:0] res_count, res_err_cnt;
    logic [W:0]    res_max_ae;
    logic [AW-1:0] res_sae, res_sse;

    logic           s_in_ready, s_busy, s_res_valid;
    logic [CW-1:0]  s_res_count, s_res_err_cnt;
    logic [W:0]     s_res_max_ae;
    logic [AWS-1:0] s_res_sae, s_res_sse;

    approx_err_monitor #(.WIDTH(W), .APPROX_BITS(AB), .CNT_W(CW), .ACC_W(AW)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .win_len(win_len),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .busy(busy), .res_valid(res_valid), .res_ack(res_ack),
        .res_count(res_count), .res_err_cnt(res_err_cnt), .res_max_ae(res_max_ae),
        .res_sae(res_sae), .res_sse(res_sse)
    );

    approx_err_monitor #(.WIDTH(W), .APPROX_BITS(AB), .CNT_W(CW), .ACC_W(AWS)) u_sat (
        .clk(clk), .rst_n(rst_n), .start(start), .win_len(win_len),
        .in_valid(in_valid), .in_ready(s_in_ready), .in_a(in_a), .in_b(in_b),
        .busy(s_busy), .res_valid(s_res_valid), .res_ack(res_ack),
        .res_count(s_res_count), .res_err_cnt(s_res_err_cnt), .res_max_ae(s_res_max_ae),
        .res_sae(s_res_sae), .res_sse(s_res_sse)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Model state
    int     q_a[$], q_b[$];
    int     d_a[$], d_b[$];
    longint e_count, e_err, e_max, e_sae, e_sse, e_sae_s, e_sse_s;
    bit     e_ok   = 1'b0;
    bit     m_open = 1'b0;
    int     m_len  = 0;
    int     m_acc  = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ETA-I approximate sum from the arithmetic description.
    function automatic int ref_approx(input int a, input int b);
        int up, lo, k;
        up = ((a >> AB) + (b >> AB)) << AB;
        lo = (a ^ b) & ((1 << AB) - 1);
        k  = AB - 1;
        while (k >= 0 && !((((a >> k) & 1) == 1) && (((b >> k) & 1) == 1))) k--;
        if (k >= 0) lo = lo | ((1 << (k + 1)) - 1);
        return up | lo;
    endfunction

    task automatic model_window();
        longint ex, ap, ae, lim;
        e_count = q_a.size();
        e_err = 0; e_max = 0; e_sae = 0; e_sse = 0;
        foreach (q_a[i]) begin
            ex = q_a[i] + q_b[i];
            ap = ref_approx(q_a[i], q_b[i]);
            ae = (ex > ap) ? ex - ap : ap - ex;
            if (ae != 0) e_err++;
            if (ae > e_max) e_max = ae;
            e_sae += ae;
            e_sse += ae * ae;
        end
        lim     = (64'sd1 <<< AWS) - 1;
        e_sae_s = (e_sae > lim) ? lim : e_sae;
        e_sse_s = (e_sse > lim) ? lim : e_sse;
    endtask

    // Compare process: results whenever valid, plus handshake invariants.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("sat_valid_match", 128'(s_res_valid), 128'(res_valid));
            if (!e_ok) chk("res_valid_early", 128'(res_valid), 128'd0);
            if (e_ok && res_valid) begin
                chk("count",   128'(res_count),     128'(e_count));
                chk("err_cnt", 128'(res_err_cnt),   128'(e_err));
                chk("max_ae",  128'(res_max_ae),    128'(e_max));
                chk("sae",     128'(res_sae),       128'(e_sae));
                chk("sse",     128'(res_sse),       128'(e_sse));
                chk("s_count", 128'(s_res_count),   128'(e_count));
                chk("s_sae",   128'(s_res_sae),     128'(e_sae_s));
                chk("s_sse",   128'(s_res_sse),     128'(e_sse_s));
            end
            if (m_open && m_acc == m_len) chk("in_ready_after_last", 128'(in_ready), 128'd0);
        end
    end

    task automatic run_window(input int len, input int vprob, input bit noise, input bit fixed_ff);
        int cyc, k;
        @(negedge clk);
        start = 1'b1; win_len = CW'(len);
        q_a.delete(); q_b.delete();
        e_ok = 1'b0;
        m_len = len; m_acc = 0; m_open = 1'b1;
        if (len == 0) begin
            model_window();
            e_ok = 1'b1;
        end
        @(negedge clk);
        start = 1'b0;
        if (len == 0) begin
            chk("zero_win_valid_1cyc", 128'(res_valid), 128'd1);
        end else begin
            cyc = 0;
            while (m_acc < len && cyc < 40 * len + 50) begin
                in_valid = ($urandom_range(99) < vprob);
                if (fixed_ff) begin
                    in_a = 8'hFF; in_b = 8'hFF;
                end else if (d_a.size() > 0) begin
                    in_a = W'(d_a[0]); in_b = W'(d_b[0]);
                end else begin
                    in_a = W'($urandom_range(255)); in_b = W'($urandom_range(255));
                end
                if (noise) begin
                    start   = ($urandom_range(2) == 0);
                    res_ack = ($urandom_range(2) == 0);
                end
                #4;
                if (in_valid && in_ready) begin
                    q_a.push_back(int'(in_a)); q_b.push_back(int'(in_b));
                    if (d_a.size() > 0) begin
                        void'(d_a.pop_front()); void'(d_b.pop_front());
                    end
                    m_acc++;
                end
                @(negedge clk);
                cyc++;
            end
            in_valid = 1'b0; start = 1'b0; res_ack = 1'b0;
            chk("accept_count", 128'(m_acc), 128'(len));
            model_window();
            e_ok = 1'b1;
            k = 0;
            while (!res_valid && k < 20) begin
                @(negedge clk);
                k++;
            end
            chk("res_valid_timeout", 128'(res_valid), 128'd1);
            chk("res_valid_min_latency", 128'(k >= 3), 128'd1);
        end
        repeat (3) @(negedge clk);
        chk("res_valid_hold", 128'(res_valid), 128'd1);
        res_ack = 1'b1;
        @(negedge clk);
        res_ack = 1'b0;
        m_open = 1'b0;
        chk("ack_busy", 128'(busy), 128'd0);
        chk("ack_res_valid", 128'(res_valid), 128'd0);
        chk("ack_count_held", 128'(res_count), 128'(e_count));
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; win_len = '0; in_valid = 1'b0;
        in_a = '0; in_b = '0; res_ack = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_in_ready", 128'(in_ready), 128'd0);
        chk("rst_res_valid", 128'(res_valid), 128'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_count", 128'(res_count), 128'd0);
        chk("rst_sae", 128'(res_sae), 128'd0);
        chk("rst_sse", 128'(res_sse), 128'd0);
        chk("rst_max", 128'(res_max_ae), 128'd0);

        // Pin the reference adder to hand-worked values.
        chk("model_0f_01", 128'(ref_approx(8'h0F, 8'h01)), 128'h0F);
        chk("model_12_21", 128'(ref_approx(8'h12, 8'h21)), 128'h33);
        chk("model_33_11", 128'(ref_approx(8'h33, 8'h11)), 128'h43);
        chk("model_ff_ff", 128'(ref_approx(8'hFF, 8'hFF)), 128'h1EF);

        // Single error case
        d_a = '{8'h0F}; d_b = '{8'h01};
        run_window(1, 100, 1'b0, 1'b0);
        chk("single_count", 128'(res_count), 128'd1);
        chk("single_sae", 128'(res_sae), 128'd1);
        chk("single_sse", 128'(res_sse), 128'd1);
        chk("single_max", 128'(res_max_ae), 128'd1);
        chk("single_err", 128'(res_err_cnt), 128'd1);

        // Mixed window
        d_a = '{8'h0F, 8'h12, 8'h33}; d_b = '{8'h01, 8'h21, 8'h11};
        run_window(3, 60, 1'b0, 1'b0);
        chk("mixed_count", 128'(res_count), 128'd3);
        chk("mixed_sae", 128'(res_sae), 128'd2);
        chk("mixed_sse", 128'(res_sse), 128'd2);
        chk("mixed_max", 128'(res_max_ae), 128'd1);
        chk("mixed_err", 128'(res_err_cnt), 128'd2);

        // Handshake with start/res_ack noise during RUN
        for (int i = 0; i < 3; i++) run_window(3, 50, 1'b1, 1'b0);

        // Zero window
        run_window(0, 100, 1'b0, 1'b0);
        chk("zero_count", 128'(res_count), 128'd0);
        chk("zero_sse", 128'(res_sse), 128'd0);

        // Random windows
        for (int i = 0; i < 20; i++)
            run_window($urandom_range(1, 12), $urandom_range(30, 100), 1'($urandom_range(1)), 1'b0);

        // Reset asserted mid-window
        @(negedge clk);
        e_ok = 1'b0;
        start = 1'b1; win_len = CW'(5);
        @(negedge clk);
        start = 1'b0; in_valid = 1'b1; in_a = 8'h0F; in_b = 8'h01;
        repeat (2) @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_reset_busy", 128'(busy), 128'd1);
        chk("pre_reset_sae", 128'(res_sae), 128'd2);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 128'(busy), 128'd0);
        chk("mid_rst_res_valid", 128'(res_valid), 128'd0);
        chk("mid_rst_in_ready", 128'(in_ready), 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_count", 128'(res_count), 128'd0);
        chk("post_rst_err", 128'(res_err_cnt), 128'd0);
        chk("post_rst_max", 128'(res_max_ae), 128'd0);
        chk("post_rst_sae", 128'(res_sae), 128'd0);
        chk("post_rst_sse", 128'(res_sse), 128'd0);

        // Saturation: 1200 * 225 exceeds the 18-bit SSE range.
        run_window(1200, 100, 1'b0, 1'b1);
        chk("sat_sse_pinned", 128'(s_res_sse), 128'h3FFFF);
        chk("sat_sae", 128'(s_res_sae), 128'd18000);
        chk("wide_sse", 128'(res_sse), 128'd270000);
        chk("wide_max", 128'(res_max_ae), 128'd15);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
